// File: rtl/alu_rs_pkg.sv
// Shared constants for the ALU reservation station: data word width,
// default geometry, and the RISC-V opcodes that this station accepts.
package alu_rs_pkg;

    localparam int WORD_W       = 32;
    localparam int RS_SIZE_DEF  = 16;
    localparam int RS_IDX_W_DEF = 4;
    localparam int ROB_W_DEF    = 4;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_ALUI   = 7'b0010011,
        OP_ALU    = 7'b0110011
    } opcode_e;

endpackage

// File: rtl/alu_rs_select.sv
// Combinational one-of-N picker for the ALU reservation station.
// Default: lowest-index requester wins.
// With ALU_RS_AGE_ORDER_EN: the requester with the oldest wrapping stamp
// wins; tying all stamps to zero degrades to lowest-index, which is how the
// free-slot search reuses this block.
module rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = 4
`ifdef ALU_RS_AGE_ORDER_EN
    ,
    parameter int STAMP_W = 5
`endif
) (
    input  logic [N-1:0]              req,
`ifdef ALU_RS_AGE_ORDER_EN
    input  logic [N-1:0][STAMP_W-1:0] stamp,
`endif
    output logic                      found,
    output logic [IDX_W-1:0]          idx
);

`ifdef ALU_RS_AGE_ORDER_EN
    logic [STAMP_W-1:0] best;
    logic [STAMP_W-1:0] diff;

    // Oldest stamp wins; a negative wrapped difference means "older".
    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '0;
        diff  = '0;
        for (int i = 0; i < N; i++) begin
            diff = stamp[i] - best;
            if (req[i] && (!found || diff[STAMP_W-1])) begin
                found = 1'b1;
                idx   = IDX_W'(i);
                best  = stamp[i];
            end
        end
    end
`else
    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ALU/branch/jump instructions,
// snoops the ALU and LSB result broadcasts for missing operands, and issues
// at most one operand-complete instruction per cycle to the ALU.
// Optional build macro ALU_RS_AGE_ORDER_EN selects oldest-first issue
// instead of lowest-index-first.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int RS_IDX_W = RS_IDX_W_DEF,
    parameter int ROB_W    = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              dsp_valid,
    input  logic [6:0]        dsp_opcode,
    input  logic [2:0]        dsp_funct3,
    input  logic              dsp_funct7,
    input  logic [WORD_W-1:0] dsp_rs1_val,
    input  logic [ROB_W-1:0]  dsp_rs1_tag,
    input  logic              dsp_rs1_rdy,
    input  logic [WORD_W-1:0] dsp_rs2_val,
    input  logic [ROB_W-1:0]  dsp_rs2_tag,
    input  logic              dsp_rs2_rdy,
    input  logic [WORD_W-1:0] dsp_imm,
    input  logic [WORD_W-1:0] dsp_pc,
    input  logic [ROB_W-1:0]  dsp_rob_pos,
    output logic              rs_full,
    input  logic              alu_cdb_valid,
    input  logic [ROB_W-1:0]  alu_cdb_rob,
    input  logic [WORD_W-1:0] alu_cdb_val,
    input  logic              lsb_cdb_valid,
    input  logic [ROB_W-1:0]  lsb_cdb_rob,
    input  logic [WORD_W-1:0] lsb_cdb_val,
    output logic              alu_enable,
    output logic [6:0]        alu_opcode,
    output logic [2:0]        alu_funct3,
    output logic              alu_funct7,
    output logic [WORD_W-1:0] alu_val1,
    output logic [WORD_W-1:0] alu_val2,
    output logic [WORD_W-1:0] alu_imm,
    output logic [WORD_W-1:0] alu_pc,
    output logic [ROB_W-1:0]  alu_rob_pos
);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] e_rdy1;
    logic [RS_SIZE-1:0] e_rdy2;
    logic [6:0]         e_opcode [RS_SIZE];
    logic [2:0]         e_funct3 [RS_SIZE];
    logic               e_funct7 [RS_SIZE];
    logic [WORD_W-1:0]  e_val1   [RS_SIZE];
    logic [WORD_W-1:0]  e_val2   [RS_SIZE];
    logic [ROB_W-1:0]   e_tag1   [RS_SIZE];
    logic [ROB_W-1:0]   e_tag2   [RS_SIZE];
    logic [WORD_W-1:0]  e_imm    [RS_SIZE];
    logic [WORD_W-1:0]  e_pc     [RS_SIZE];
    logic [ROB_W-1:0]   e_rob    [RS_SIZE];

    logic [RS_SIZE-1:0]  eligible;
    logic                iss_found;
    logic [RS_IDX_W-1:0] iss_idx;
    logic                free_found;
    logic [RS_IDX_W-1:0] free_idx;
    logic                dsp_accept;

`ifdef ALU_RS_AGE_ORDER_EN
    localparam int STAMP_W = RS_IDX_W + 1;
    logic [RS_SIZE-1:0][STAMP_W-1:0] e_stamp;
    logic [STAMP_W-1:0]              age_cnt;
`endif

    assign eligible   = busy & e_rdy1 & e_rdy2;
    assign rs_full    = &busy;
    assign dsp_accept = dsp_valid && free_found;

    // Resolve an operand: already valid, or captured from a matching
    // broadcast this cycle (ALU broadcast takes priority over LSB).
    function automatic logic [WORD_W:0] snoop(
        input logic              op_rdy,
        input logic [WORD_W-1:0] op_val,
        input logic [ROB_W-1:0]  op_tag
    );
        if (op_rdy)
            return {1'b1, op_val};
        if (alu_cdb_valid && alu_cdb_rob == op_tag)
            return {1'b1, alu_cdb_val};
        if (lsb_cdb_valid && lsb_cdb_rob == op_tag)
            return {1'b1, lsb_cdb_val};
        return {1'b0, op_val};
    endfunction

    rs_select #(
        .N     (RS_SIZE),
        .IDX_W (RS_IDX_W)
`ifdef ALU_RS_AGE_ORDER_EN
        ,
        .STAMP_W (STAMP_W)
`endif
    ) u_issue_sel (
        .req   (eligible),
`ifdef ALU_RS_AGE_ORDER_EN
        .stamp (e_stamp),
`endif
        .found (iss_found),
        .idx   (iss_idx)
    );

    rs_select #(
        .N     (RS_SIZE),
        .IDX_W (RS_IDX_W)
`ifdef ALU_RS_AGE_ORDER_EN
        ,
        .STAMP_W (STAMP_W)
`endif
    ) u_free_sel (
        .req   (~busy),
`ifdef ALU_RS_AGE_ORDER_EN
        .stamp ('0),
`endif
        .found (free_found),
        .idx   (free_idx)
    );

    // Entry payload: operand wakeup from both broadcasts, then dispatch write.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !e_rdy1[i])
                    {e_rdy1[i], e_val1[i]} <= snoop(1'b0, e_val1[i], e_tag1[i]);
                if (busy[i] && !e_rdy2[i])
                    {e_rdy2[i], e_val2[i]} <= snoop(1'b0, e_val2[i], e_tag2[i]);
                if (dsp_accept && free_idx == RS_IDX_W'(i)) begin
                    e_opcode[i] <= dsp_opcode;
                    e_funct3[i] <= dsp_funct3;
                    e_funct7[i] <= dsp_funct7;
                    e_tag1[i]   <= dsp_rs1_tag;
                    e_tag2[i]   <= dsp_rs2_tag;
                    e_imm[i]    <= dsp_imm;
                    e_pc[i]     <= dsp_pc;
                    e_rob[i]    <= dsp_rob_pos;
                    {e_rdy1[i], e_val1[i]} <= snoop(dsp_rs1_rdy, dsp_rs1_val, dsp_rs1_tag);
                    {e_rdy2[i], e_val2[i]} <= snoop(dsp_rs2_rdy, dsp_rs2_val, dsp_rs2_tag);
`ifdef ALU_RS_AGE_ORDER_EN
                    e_stamp[i]  <= age_cnt;
`endif
                end
            end
        end
    end

    // Occupancy, issue port and age counter; reset/rollback flush everything.
    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            busy        <= '0;
            alu_enable  <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
`ifdef ALU_RS_AGE_ORDER_EN
            age_cnt     <= '0;
`endif
        end else if (rdy) begin
            if (iss_found) begin
                alu_enable    <= 1'b1;
                alu_opcode    <= e_opcode[iss_idx];
                alu_funct3    <= e_funct3[iss_idx];
                alu_funct7    <= e_funct7[iss_idx];
                alu_val1      <= e_val1[iss_idx];
                alu_val2      <= e_val2[iss_idx];
                alu_imm       <= e_imm[iss_idx];
                alu_pc        <= e_pc[iss_idx];
                alu_rob_pos   <= e_rob[iss_idx];
                busy[iss_idx] <= 1'b0;
            end else begin
                alu_enable    <= 1'b0;
            end
            if (dsp_accept) begin
                busy[free_idx] <= 1'b1;
`ifdef ALU_RS_AGE_ORDER_EN
                age_cnt        <= age_cnt + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: directed scenarios plus randomized traffic checked
// against a behavioural model of the reservation station.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        dsp_valid;
    logic [6:0]  dsp_opcode;
    logic [2:0]  dsp_funct3;
    logic        dsp_funct7;
    logic [31:0] dsp_rs1_val, dsp_rs2_val, dsp_imm, dsp_pc;
    logic [3:0]  dsp_rs1_tag, dsp_rs2_tag, dsp_rob_pos;
    logic        dsp_rs1_rdy, dsp_rs2_rdy;
    logic        rs_full;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_rob, lsb_cdb_rob;
    logic [31:0] alu_cdb_val, lsb_cdb_val;
    logic        alu_enable;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    alu_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .dsp_valid(dsp_valid), .dsp_opcode(dsp_opcode), .dsp_funct3(dsp_funct3),
        .dsp_funct7(dsp_funct7), .dsp_rs1_val(dsp_rs1_val), .dsp_rs1_tag(dsp_rs1_tag),
        .dsp_rs1_rdy(dsp_rs1_rdy), .dsp_rs2_val(dsp_rs2_val), .dsp_rs2_tag(dsp_rs2_tag),
        .dsp_rs2_rdy(dsp_rs2_rdy), .dsp_imm(dsp_imm), .dsp_pc(dsp_pc),
        .dsp_rob_pos(dsp_rob_pos), .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- behavioural model: a set of waiting instructions, each slot numbered
    typedef struct {
        bit        busy;
        bit [6:0]  op;
        bit [2:0]  f3;
        bit        f7;
        bit [31:0] v1, v2, imm, pc;
        bit [3:0]  t1, t2, rob;
        bit        r1, r2;
        int        seq;
    } ent_t;

    ent_t      m [16];
    bit        m_en;
    bit [6:0]  m_op;
    bit [2:0]  m_f3;
    bit        m_f7;
    bit [31:0] m_v1, m_v2, m_imm, m_pc;
    bit [3:0]  m_rob;
    int        m_seq = 0;

    function automatic bit m_full();
        for (int i = 0; i < 16; i++)
            if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // An operand still waiting picks up a broadcast value whose tag matches.
    function automatic ent_t wake(input ent_t e);
        ent_t r = e;
        if (!r.r1) begin
            if (alu_cdb_valid && alu_cdb_rob == r.t1) begin r.r1 = 1; r.v1 = alu_cdb_val; end
            else if (lsb_cdb_valid && lsb_cdb_rob == r.t1) begin r.r1 = 1; r.v1 = lsb_cdb_val; end
        end
        if (!r.r2) begin
            if (alu_cdb_valid && alu_cdb_rob == r.t2) begin r.r2 = 1; r.v2 = alu_cdb_val; end
            else if (lsb_cdb_valid && lsb_cdb_rob == r.t2) begin r.r2 = 1; r.v2 = lsb_cdb_val; end
        end
        return r;
    endfunction

    task automatic model_step();
        int   pick;
        int   slot;
        ent_t e;
        if (rst || rollback) begin
            for (int i = 0; i < 16; i++) m[i].busy = 0;
            m_en = 0; m_op = 0; m_f3 = 0; m_f7 = 0;
            m_v1 = 0; m_v2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
            return;
        end
        if (!rdy) return;
        pick = -1;
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy && m[i].r1 && m[i].r2) begin
`ifdef ALU_RS_AGE_ORDER_EN
                if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        slot = -1;
        for (int i = 0; i < 16; i++)
            if (!m[i].busy && slot < 0) slot = i;
        if (pick >= 0) begin
            m_en = 1; m_op = m[pick].op; m_f3 = m[pick].f3; m_f7 = m[pick].f7;
            m_v1 = m[pick].v1; m_v2 = m[pick].v2; m_imm = m[pick].imm;
            m_pc = m[pick].pc; m_rob = m[pick].rob;
        end else begin
            m_en = 0;
        end
        for (int i = 0; i < 16; i++)
            if (m[i].busy) m[i] = wake(m[i]);
        if (pick >= 0) m[pick].busy = 0;
        if (dsp_valid && slot >= 0) begin
            e.busy = 1; e.op = dsp_opcode; e.f3 = dsp_funct3; e.f7 = dsp_funct7;
            e.v1 = dsp_rs1_val; e.t1 = dsp_rs1_tag; e.r1 = dsp_rs1_rdy;
            e.v2 = dsp_rs2_val; e.t2 = dsp_rs2_tag; e.r2 = dsp_rs2_rdy;
            e.imm = dsp_imm; e.pc = dsp_pc; e.rob = dsp_rob_pos;
            e.seq = m_seq;
            m_seq++;
            m[slot] = wake(e);
        end
    endtask

    // One clock: check occupancy, advance the model, then compare the issue port.
    task automatic tick();
        chk("full", rs_full, m_full());
        model_step();
        @(posedge clk);
        #1;
        chk("en", alu_enable, m_en);
        chk("op", {alu_opcode, alu_funct3, alu_funct7}, {m_op, m_f3, m_f7});
        chk("val1", alu_val1, m_v1);
        chk("val2", alu_val2, m_v2);
        chk("imm", alu_imm, m_imm);
        chk("pc", alu_pc, m_pc);
        chk("rob", alu_rob_pos, m_rob);
    endtask

    task automatic clr();
        rst = 0; rollback = 0; rdy = 1;
        dsp_valid = 0; dsp_opcode = 0; dsp_funct3 = 0; dsp_funct7 = 0;
        dsp_rs1_val = 0; dsp_rs1_tag = 0; dsp_rs1_rdy = 0;
        dsp_rs2_val = 0; dsp_rs2_tag = 0; dsp_rs2_rdy = 0;
        dsp_imm = 0; dsp_pc = 0; dsp_rob_pos = 0;
        alu_cdb_valid = 0; alu_cdb_rob = 0; alu_cdb_val = 0;
        lsb_cdb_valid = 0; lsb_cdb_rob = 0; lsb_cdb_val = 0;
    endtask

    task automatic set_dsp(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                           input bit [31:0] v1, input bit [3:0] t1, input bit r1,
                           input bit [31:0] v2, input bit [3:0] t2, input bit r2,
                           input bit [31:0] imm, input bit [31:0] pc, input bit [3:0] rob);
        dsp_valid = 1; dsp_opcode = op; dsp_funct3 = f3; dsp_funct7 = f7;
        dsp_rs1_val = v1; dsp_rs1_tag = t1; dsp_rs1_rdy = r1;
        dsp_rs2_val = v2; dsp_rs2_tag = t2; dsp_rs2_rdy = r2;
        dsp_imm = imm; dsp_pc = pc; dsp_rob_pos = rob;
    endtask

    bit [6:0] ops [7] = '{OP_ALU, OP_ALUI, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    initial begin
        clr();
        rst = 1;
        model_step();
        @(posedge clk); #1;
        model_step();
        @(posedge clk); #1;
        rst = 0;
        chk("rst_en", alu_enable, 0);
        chk("rst_full", rs_full, 0);
        chk("rst_rob", alu_rob_pos, 0);

        // reset dominates a pending, ready instruction
        set_dsp(OP_ALUI, 0, 0, 5, 0, 1, 0, 0, 1, 7, 32'h100, 3);
        tick();
        clr(); rst = 1;
        tick();
        chk("t1_en", alu_enable, 0);
        rst = 0;
        repeat (3) begin
            tick();
            chk("t1_noiss", alu_enable, 0);
        end
        chk("t1_full", rs_full, 0);

        // ready dispatch issues on the next edge
        set_dsp(OP_ALU, 0, 0, 10, 0, 1, 20, 0, 1, 0, 32'h200, 2);
        tick();
        clr();
        tick();
        chk("t2_en", alu_enable, 1);
        chk("t2_val1", alu_val1, 10);
        chk("t2_val2", alu_val2, 20);
        chk("t2_rob", alu_rob_pos, 2);
        tick();
        chk("t2_en_off", alu_enable, 0);

        // same-cycle broadcast bypass on dispatch
        set_dsp(OP_ALU, 0, 1, 0, 5, 0, 3, 0, 1, 0, 32'h204, 4);
        alu_cdb_valid = 1; alu_cdb_rob = 5; alu_cdb_val = 32'h1234;
        tick();
        clr();
        tick();
        chk("t3_en", alu_enable, 1);
        chk("t3_val1", alu_val1, 32'h1234);
        chk("t3_f7", alu_funct7, 1);

        // late wakeup from the LSB broadcast
        set_dsp(OP_BRANCH, 3'b001, 0, 8, 0, 1, 0, 7, 0, 32'h10, 32'h300, 5);
        tick();
        clr();
        repeat (3) begin
            tick();
            chk("t4_wait", alu_enable, 0);
        end
        lsb_cdb_valid = 1; lsb_cdb_rob = 7; lsb_cdb_val = 32'hFFFF_FFFF;
        tick();
        chk("t4_wake_edge", alu_enable, 0);
        clr();
        tick();
        chk("t4_en", alu_enable, 1);
        chk("t4_val2", alu_val2, 32'hFFFF_FFFF);
        chk("t4_rob", alu_rob_pos, 5);

        // fill all entries, then flush
        for (int k = 0; k < 16; k++) begin
            set_dsp(OP_ALU, 0, 0, 0, 9, 0, k, 0, 1, 0, 32'h1000 + k, k[3:0]);
            tick();
        end
        clr();
        chk("t5_full", rs_full, 1);
        rollback = 1;
        tick();
        clr();
        chk("t5_flushed", rs_full, 0);
        alu_cdb_valid = 1; alu_cdb_rob = 9; alu_cdb_val = 32'h55;
        tick();
        clr();
        chk("t5_no_en0", alu_enable, 0);
        tick();
        chk("t5_no_en1", alu_enable, 0);

        // stall freezes the issue port
        set_dsp(OP_ALU, 0, 0, 1, 0, 1, 2, 0, 1, 0, 32'h400, 6);
        tick();
        set_dsp(OP_ALU, 0, 0, 3, 0, 1, 4, 0, 1, 0, 32'h404, 7);
        tick();
        chk("t6_en", alu_enable, 1);
        chk("t6_rob", alu_rob_pos, 6);
        clr(); rdy = 0;
        repeat (4) begin
            tick();
            chk("t6_hold_en", alu_enable, 1);
            chk("t6_hold_rob", alu_rob_pos, 6);
            chk("t6_hold_pc", alu_pc, 32'h400);
        end
        rdy = 1;
        tick();
        chk("t6_resume_en", alu_enable, 1);
        chk("t6_resume_rob", alu_rob_pos, 7);
        tick();
        chk("t6_idle", alu_enable, 0);

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            clr();
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 79) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            if (!m_full() && $urandom_range(0, 2) != 0)
                set_dsp(ops[$urandom_range(0, 6)], 3'($urandom), 1'($urandom),
                        $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
                        $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
                        $urandom, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                alu_cdb_valid = 1; alu_cdb_rob = 4'($urandom); alu_cdb_val = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                lsb_cdb_valid = 1; lsb_cdb_rob = 4'($urandom); lsb_cdb_val = $urandom;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
